// File: rtl/grade_accumulator_if.sv
// Score-entry bus between the switch/button front end and the grade accumulator.
interface grade_accumulator_if;
  logic [3:0] nota_in;
  logic       enter;
  logic       clear;
  logic [3:0] nota;
  logic       nota_valid;
  logic [3:0] count;
  logic       erro;

  // Driver side: switches and buttons.
  modport master (
    output nota_in, enter, clear,
    input  nota, nota_valid, count, erro
  );

  // Accumulator side.
  modport slave (
    input  nota_in, enter, clear,
    output nota, nota_valid, count, erro
  );
endinterface

// File: rtl/grade_accumulator.sv
// Collects NUM_NOTAS partial scores (0..9), submitted by rising edges of an
// asynchronous enter switch, and produces their floor average.
module grade_accumulator #(
  parameter int unsigned NUM_NOTAS = 4
) (
  input  logic                clk_2,
  input  logic                reset,
  grade_accumulator_if.slave  bus
);

  localparam int unsigned ShiftW  = $clog2(NUM_NOTAS);
  localparam int unsigned SumW    = 4 + ShiftW;
  localparam logic [3:0]  LastCnt = 4'(NUM_NOTAS - 1);

  // Power-of-two averaging is done by shifting, so only 2, 4 and 8 are usable.
  if (!(NUM_NOTAS == 2 || NUM_NOTAS == 4 || NUM_NOTAS == 8)) begin : g_bad_num_notas
    $error("grade_accumulator: NUM_NOTAS must be 2, 4 or 8");
  end

  typedef enum logic [1:0] {StColeta, StCalcula, StPronto} state_e;

  logic            enter_s1_q, enter_s2_q, enter_hist_q;
  logic            submit;
  logic            nota_ok;
  state_e          state_q;
  logic [SumW-1:0] sum_q;
  logic [3:0]      count_q;
  logic [3:0]      nota_q;
  logic            nota_valid_q;
  logic            erro_q;

  // Two-flop synchronizer for enter plus a history flop for edge detection.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      enter_s1_q   <= 1'b0;
      enter_s2_q   <= 1'b0;
      enter_hist_q <= 1'b0;
    end else begin
      enter_s1_q   <= bus.enter;
      enter_s2_q   <= enter_s1_q;
      enter_hist_q <= enter_s2_q;
    end
  end

  assign submit  = enter_s2_q & ~enter_hist_q;
  assign nota_ok = (bus.nota_in <= 4'd9);

  // Collection FSM with registered outputs; clear overrides any submit.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state_q      <= StColeta;
      sum_q        <= '0;
      count_q      <= '0;
      nota_q       <= '0;
      nota_valid_q <= 1'b0;
      erro_q       <= 1'b0;
    end else if (bus.clear) begin
      state_q      <= StColeta;
      sum_q        <= '0;
      count_q      <= '0;
      nota_q       <= '0;
      nota_valid_q <= 1'b0;
      erro_q       <= 1'b0;
    end else begin
      case (state_q)
        StColeta: begin
          if (submit) begin
            if (nota_ok) begin
              sum_q   <= sum_q + SumW'(bus.nota_in);
              count_q <= count_q + 4'd1;
              erro_q  <= 1'b0;
              if (count_q == LastCnt) begin
                state_q <= StCalcula;
              end
            end else begin
              erro_q <= 1'b1;
            end
          end
        end
        StCalcula: begin
          nota_q       <= 4'(sum_q >> ShiftW);
          nota_valid_q <= 1'b1;
          state_q      <= StPronto;
        end
        StPronto: begin
          // Result held until clear or reset; submits are ignored.
        end
        default: begin
          state_q <= StColeta;
        end
      endcase
    end
  end

  assign bus.nota       = nota_q;
  assign bus.nota_valid = nota_valid_q;
  assign bus.count      = count_q;
  assign bus.erro       = erro_q;

endmodule

// File: tb/tb_grade_accumulator.sv
// Self-checking bench for grade_accumulator with NUM_NOTAS = 4.
module tb_grade_accumulator;
  localparam int N = 4;

  logic clk_2 = 1'b0;
  logic reset;

  grade_accumulator_if bus ();

  grade_accumulator #(.NUM_NOTAS(N)) dut (
    .clk_2 (clk_2),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk_2 = ~clk_2;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_q[$];
  int   m_cnt, m_sum;
  logic m_err, m_done;
  logic prev_valid = 1'b0;

  // Scoreboard: each rising nota_valid consumes one expected average.
  always @(negedge clk_2) begin
    if (bus.nota_valid === 1'b1 && prev_valid !== 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: nota_valid rose with nota=%0d, no result expected", bus.nota);
      end else begin
        if (bus.nota !== 4'(exp_q[0])) begin
          n_bad++;
          $display("FAIL sb_nota: got %0d expected %0d", bus.nota, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
    prev_valid <= bus.nota_valid;
  end

  function automatic void model_clear();
    m_cnt  = 0;
    m_sum  = 0;
    m_err  = 1'b0;
    m_done = 1'b0;
  endfunction

  function automatic void model_submit(input int v);
    if (m_done) return;
    if (v <= 9) begin
      m_cnt++;
      m_sum += v;
      m_err = 1'b0;
      if (m_cnt == N) begin
        m_done = 1'b1;
        exp_q.push_back(m_sum / N);
      end
    end else begin
      m_err = 1'b1;
    end
  endfunction

  // One full enter press/release; outputs are settled on return.
  task automatic submit(input int v);
    @(negedge clk_2);
    bus.nota_in = 4'(v);
    bus.enter   = 1'b1;
    model_submit(v);
    repeat (3) @(negedge clk_2);
    bus.enter = 1'b0;
    repeat (3) @(negedge clk_2);
  endtask

  task automatic clear_pulse();
    @(negedge clk_2);
    bus.clear = 1'b1;
    @(negedge clk_2);
    bus.clear = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    bus.nota_in = 4'd0;
    bus.enter   = 1'b0;
    bus.clear   = 1'b0;
    model_clear();
    #12;
    n_cmp++;
    if ({bus.nota, bus.nota_valid, bus.count, bus.erro} !== 10'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got nota=%0d valid=%b count=%0d erro=%b expected all 0",
               bus.nota, bus.nota_valid, bus.count, bus.erro);
    end
    @(negedge clk_2);
    reset = 1'b0;
  endtask

  task automatic test_latency();
    clear_pulse();
    @(negedge clk_2);
    bus.nota_in = 4'd6;
    bus.enter   = 1'b1;
    model_submit(6);
    repeat (2) @(negedge clk_2);
    n_cmp++;
    if (bus.count !== 4'd0) begin
      n_bad++;
      $display("FAIL latency_early: count=%0d after 2 edges, expected 0", bus.count);
    end
    @(negedge clk_2);
    n_cmp++;
    if (bus.count !== 4'd1) begin
      n_bad++;
      $display("FAIL latency_3edges: count=%0d after 3 edges, expected 1", bus.count);
    end
    bus.enter = 1'b0;
    repeat (3) @(negedge clk_2);
  endtask

  task automatic test_average(input int a, input int b, input int c, input int d);
    int s[4];
    s = '{a, b, c, d};
    clear_pulse();
    for (int i = 0; i < 4; i++) begin
      submit(s[i]);
      n_cmp++;
      if (bus.count !== 4'(m_cnt)) begin
        n_bad++;
        $display("FAIL avg_count[%0d]: got %0d expected %0d", i, bus.count, m_cnt);
      end
    end
    n_cmp++;
    if (bus.nota_valid !== 1'b1 || bus.nota !== 4'(m_sum / N)) begin
      n_bad++;
      $display("FAIL avg_result: got nota=%0d valid=%b expected nota=%0d valid=1",
               bus.nota, bus.nota_valid, m_sum / N);
    end
  endtask

  task automatic test_pronto_clear();
    submit(3);
    n_cmp++;
    if (bus.nota !== 4'd7 || bus.count !== 4'd4 || bus.nota_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL pronto_hold: got nota=%0d count=%0d valid=%b expected 7/4/1",
               bus.nota, bus.count, bus.nota_valid);
    end
    clear_pulse();
    n_cmp++;
    if (bus.nota_valid !== 1'b0 || bus.count !== 4'd0 || bus.nota !== 4'd0) begin
      n_bad++;
      $display("FAIL pronto_clear: got nota=%0d count=%0d valid=%b expected 0/0/0",
               bus.nota, bus.count, bus.nota_valid);
    end
  endtask

  task automatic test_error();
    int s[3];
    s = '{5, 12, 4};
    clear_pulse();
    for (int i = 0; i < 3; i++) begin
      submit(s[i]);
      n_cmp++;
      if (bus.count !== 4'(m_cnt) || bus.erro !== m_err) begin
        n_bad++;
        $display("FAIL error_step[%0d]: got count=%0d erro=%b expected count=%0d erro=%b",
                 i, bus.count, bus.erro, m_cnt, m_err);
      end
    end
  endtask

  task automatic test_async_reset();
    clear_pulse();
    submit(3);
    submit(3);
    @(posedge clk_2);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.nota, bus.nota_valid, bus.count, bus.erro} !== 10'd0) begin
      n_bad++;
      $display("FAIL async_reset: got count=%0d nota=%0d expected immediate zero",
               bus.count, bus.nota);
    end
    #1 reset = 1'b0;
    model_clear();
    for (int i = 0; i < 4; i++) submit(4);
    n_cmp++;
    if (bus.nota !== 4'd4 || bus.nota_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL after_reset_avg: got nota=%0d valid=%b expected 4/1",
               bus.nota, bus.nota_valid);
    end
  endtask

  task automatic test_reset_held_enter();
    clear_pulse();
    @(negedge clk_2);
    bus.nota_in = 4'd2;
    bus.enter   = 1'b1;
    repeat (5) @(negedge clk_2);
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    repeat (8) @(negedge clk_2);
    n_cmp++;
    if (bus.count !== 4'd1) begin
      n_bad++;
      $display("FAIL reset_held_enter: count=%0d expected 1", bus.count);
    end
    bus.enter = 1'b0;
    repeat (3) @(negedge clk_2);
    clear_pulse();
  endtask

  task automatic test_back_to_back();
    clear_pulse();
    @(negedge clk_2);
    bus.nota_in = 4'd2;
    bus.enter   = 1'b1;
    repeat (20) @(negedge clk_2);
    n_cmp++;
    if (bus.count !== 4'd1) begin
      n_bad++;
      $display("FAIL held_enter: count=%0d expected 1", bus.count);
    end
    bus.enter = 1'b0;
    repeat (3) @(negedge clk_2);
    // Raise enter, then line clear up with the resulting submit cycle.
    bus.enter = 1'b1;
    repeat (2) @(negedge clk_2);
    bus.clear = 1'b1;
    @(negedge clk_2);
    bus.clear = 1'b0;
    model_clear();
    repeat (3) @(negedge clk_2);
    n_cmp++;
    if (bus.count !== 4'd0 || bus.erro !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_vs_submit: got count=%0d erro=%b expected 0/0", bus.count, bus.erro);
    end
    bus.enter = 1'b0;
    repeat (3) @(negedge clk_2);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_average(7, 8, 6, 9);
    test_pronto_clear();
    test_average(9, 9, 9, 9);
    test_average(0, 0, 0, 3);
    test_error();
    test_async_reset();
    test_reset_held_enter();
    test_back_to_back();
    repeat (3) @(negedge clk_2);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_leftover: %0d results never produced, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
